// File: rtl/io_bridge.sv
// io_bridge: byte-wide bridge between the CPU core's external memory port,
// main RAM and a memory-mapped UART window (cpu_addr_i[17:16] == 2'b11).
// The IO window exposes DATA (offset 0x0) and STATUS (offset 0x4) registers.
// A transmit FIFO feeds the UART transmitter; the core is halted when it
// writes DATA while that FIFO is full.
// Optional feature macro: IO_BRIDGE_RX_EN adds a receive FIFO that is popped
// by DATA reads; without it rx_ready_o is tied low and DATA reads return 0x00.
module io_bridge #(
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_addr_i,
  input  logic        cpu_wr_i,
  input  logic [7:0]  cpu_dout_i,
  output logic [7:0]  cpu_din_o,
  output logic [1:0]  halt_req_o,
  output logic [16:0] ram_addr_o,
  output logic        ram_wr_o,
  output logic [7:0]  ram_dout_o,
  input  logic [7:0]  ram_din_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o
);

  localparam int TXA = $clog2(TX_DEPTH);

  // Address decode
  logic io;
  logic is_data;
  logic is_status;
  logic io_rd;
  logic unused_addr;

  assign io          = (cpu_addr_i[17:16] == 2'b11);
  assign is_data     = (cpu_addr_i[2:0] == 3'b000);
  assign is_status   = (cpu_addr_i[2:0] == 3'b100);
  assign io_rd       = io & ~cpu_wr_i;
  assign unused_addr = ^cpu_addr_i[31:18];

  // RAM path is purely combinational
  assign ram_addr_o = cpu_addr_i[16:0];
  assign ram_dout_o = cpu_dout_i;
  assign ram_wr_o   = cpu_wr_i & ~io;

  // Transmit FIFO; pointers carry one extra wrap bit so full and empty differ
  logic [TXA:0] tx_wp;
  logic [TXA:0] tx_rp;
  logic [7:0]   tx_mem [TX_DEPTH];
  logic         tx_full;
  logic         tx_empty;
  logic         tx_push;
  logic         tx_pop;

  assign tx_full    = ((tx_wp ^ tx_rp) == {1'b1, {TXA{1'b0}}});
  assign tx_empty   = (tx_wp == tx_rp);
  assign tx_push    = io & cpu_wr_i & is_data & ~tx_full;
  assign tx_pop     = tx_valid_o & tx_ready_i;
  assign tx_valid_o = ~tx_empty;
  assign tx_data_o  = tx_mem[tx_rp[TXA-1:0]];

  // The core's halt input; a full-FIFO DATA write is dropped and re-issued
  assign halt_req_o = {1'b0, tx_full & io & cpu_wr_i & is_data};

  // TX pointer update; a push and a pop in the same cycle both take effect
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wp <= '0;
      tx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
    end
  end

  // TX storage; contents need no reset since the pointers gate visibility
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[TXA-1:0]] <= cpu_dout_i;
  end

  logic       rx_nonempty;
  logic [7:0] rx_head;
  logic       rx_pop;

  assign rx_pop = io_rd & is_data & rx_nonempty;

`ifdef IO_BRIDGE_RX_EN
  localparam int RXA = $clog2(RX_DEPTH);

  logic [RXA:0] rx_wp;
  logic [RXA:0] rx_rp;
  logic [7:0]   rx_mem [RX_DEPTH];
  logic         rx_full;
  logic         rx_push;

  assign rx_full     = ((rx_wp ^ rx_rp) == {1'b1, {RXA{1'b0}}});
  assign rx_nonempty = (rx_wp != rx_rp);
  assign rx_ready_o  = ~rx_full;
  assign rx_push     = rx_valid_i & rx_ready_o;
  assign rx_head     = rx_mem[rx_rp[RXA-1:0]];

  // RX pointer update; the pop lands at the edge ending the DATA read cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
    end
  end

  // RX storage
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp[RXA-1:0]] <= rx_data_i;
  end
`else
  logic unused_rx;

  assign rx_nonempty = 1'b0;
  assign rx_head     = 8'h00;
  assign rx_ready_o  = 1'b0;
  assign unused_rx   = ^{rx_data_i, rx_valid_i, rx_pop};
`endif

  // IO read value, taken from state at the start of the read cycle
  logic [7:0] rd_val;

  always_comb begin
    rd_val = 8'h00;
    if (is_data) begin
      rd_val = rx_nonempty ? rx_head : 8'h00;
    end else if (is_status) begin
      rd_val = {6'b0, rx_nonempty, tx_full};
    end
  end

  logic       sel_q;
  logic [7:0] io_rdata_q;

  // Read return stage: both RAM and IO answer one cycle after the address
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q      <= 1'b0;
      io_rdata_q <= 8'h00;
    end else begin
      sel_q      <= io_rd;
      io_rdata_q <= rd_val;
    end
  end

  assign cpu_din_o = sel_q ? io_rdata_q : ram_din_i;

endmodule

// File: tb/tb_io_bridge.sv
// Directed bench for io_bridge: reset state, RAM path, TX streaming, TX full
// halt and retry, STATUS reads, full-FIFO push/pop collision, RX path (either
// build) and reset in the middle of an IO read.
module tb_io_bridge;

  logic        clk;
  logic        rst;
  logic [31:0] cpu_addr_i;
  logic        cpu_wr_i;
  logic [7:0]  cpu_dout_i;
  logic [7:0]  cpu_din_o;
  logic [1:0]  halt_req_o;
  logic [16:0] ram_addr_o;
  logic        ram_wr_o;
  logic [7:0]  ram_dout_o;
  logic [7:0]  ram_din_i;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;

  int checks;
  int errors;

  io_bridge #(.TX_DEPTH(8), .RX_DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr_i(cpu_addr_i), .cpu_wr_i(cpu_wr_i), .cpu_dout_i(cpu_dout_i),
    .cpu_din_o(cpu_din_o), .halt_req_o(halt_req_o),
    .ram_addr_o(ram_addr_o), .ram_wr_o(ram_wr_o), .ram_dout_o(ram_dout_o),
    .ram_din_i(ram_din_i),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_addr_i = 32'h0000_0000;
    cpu_wr_i   = 1'b0;
    cpu_dout_i = 8'h00;
  endtask

  task automatic drive(input logic [31:0] a, input logic w, input logic [7:0] d);
    cpu_addr_i = a;
    cpu_wr_i   = w;
    cpu_dout_i = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    tx_ready_i = 1'b0;
    rx_valid_i = 1'b0;
    rx_data_i  = 8'h00;
    ram_din_i  = 8'h3C;
    cyc(); cyc();
    rst = 1'b0;
    #1;
    checks++;
    if (tx_valid_o !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b want 0", tx_valid_o); end
    checks++;
    if (halt_req_o !== 2'b00) begin errors++; $display("FAIL reset_halt got %b want 00", halt_req_o); end
    checks++;
    if (cpu_din_o !== 8'h3C) begin errors++; $display("FAIL reset_din got %h want 3c", cpu_din_o); end
    checks++;
`ifdef IO_BRIDGE_RX_EN
    if (rx_ready_o !== 1'b1) begin errors++; $display("FAIL reset_rx_ready got %b want 1", rx_ready_o); end
`else
    if (rx_ready_o !== 1'b0) begin errors++; $display("FAIL reset_rx_ready got %b want 0", rx_ready_o); end
`endif
  endtask

  task automatic test_ram();
    cyc();
    drive(32'h0000_0010, 1'b0, 8'h00);
    #1;
    checks++;
    if (ram_addr_o !== 17'h00010 || ram_wr_o !== 1'b0) begin
      errors++; $display("FAIL ram_rd_addr got %h/%b want 00010/0", ram_addr_o, ram_wr_o);
    end
    cyc();
    idle();
    ram_din_i = 8'hA5;
    #1;
    checks++;
    if (cpu_din_o !== 8'hA5) begin errors++; $display("FAIL ram_rd_data got %h want a5", cpu_din_o); end
    drive(32'h0002_ABCD, 1'b1, 8'h77);
    #1;
    checks++;
    if (ram_addr_o !== 17'h0ABCD || ram_wr_o !== 1'b1 || ram_dout_o !== 8'h77) begin
      errors++; $display("FAIL ram_wr got %h/%b/%h want 0abcd/1/77", ram_addr_o, ram_wr_o, ram_dout_o);
    end
    cyc();
    // write to an unmapped IO offset must not reach the TX FIFO
    drive(32'h0003_0001, 1'b1, 8'h55);
    #1;
    checks++;
    if (ram_wr_o !== 1'b0) begin errors++; $display("FAIL io_wr_ram_strobe got %b want 0", ram_wr_o); end
    cyc();
    idle();
    #1;
    checks++;
    if (tx_valid_o !== 1'b0) begin errors++; $display("FAIL bad_offset_push got %b want 0", tx_valid_o); end
  endtask

  task automatic test_tx_stream();
    tx_ready_i = 1'b1;
    cyc();
    drive(32'h0003_0000, 1'b1, 8'h41);
    #1;
    checks++;
    if (tx_valid_o !== 1'b0 || ram_wr_o !== 1'b0) begin
      errors++; $display("FAIL tx_no_bypass got valid %b ramwr %b want 0 0", tx_valid_o, ram_wr_o);
    end
    cyc();
    drive(32'h0003_0000, 1'b1, 8'h42);
    #1;
    checks++;
    if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h41) begin
      errors++; $display("FAIL tx_byte0 got %b/%h want 1/41", tx_valid_o, tx_data_o);
    end
    cyc();
    drive(32'h0003_0000, 1'b1, 8'h43);
    #1;
    checks++;
    if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h42) begin
      errors++; $display("FAIL tx_byte1 got %b/%h want 1/42", tx_valid_o, tx_data_o);
    end
    cyc();
    idle();
    #1;
    checks++;
    if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h43) begin
      errors++; $display("FAIL tx_byte2 got %b/%h want 1/43", tx_valid_o, tx_data_o);
    end
    cyc();
    checks++;
    if (tx_valid_o !== 1'b0) begin errors++; $display("FAIL tx_drained got %b want 0", tx_valid_o); end
  endtask

  task automatic test_tx_full();
    tx_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(32'h0003_0000, 1'b1, 8'h10 + 8'(i));
      #1;
      checks++;
      if (halt_req_o !== 2'b00) begin errors++; $display("FAIL fill_halt_%0d got %b want 00", i, halt_req_o); end
      cyc();
    end
    drive(32'h0003_0000, 1'b1, 8'h99);
    #1;
    checks++;
    if (halt_req_o !== 2'b01) begin errors++; $display("FAIL full_halt got %b want 01", halt_req_o); end
    cyc();
    // free one slot, then retry the rejected byte
    idle();
    tx_ready_i = 1'b1;
    cyc();
    tx_ready_i = 1'b0;
    drive(32'h0003_0000, 1'b1, 8'h99);
    #1;
    checks++;
    if (halt_req_o !== 2'b00) begin errors++; $display("FAIL retry_halt got %b want 00", halt_req_o); end
    cyc();
    idle();
    #1;
    checks++;
    if (tx_data_o !== 8'h11) begin errors++; $display("FAIL retry_head got %h want 11", tx_data_o); end
  endtask

  task automatic test_status();
    ram_din_i = 8'hFF;
    drive(32'h0003_0004, 1'b0, 8'h00);
    cyc();
    drive(32'h0003_0002, 1'b0, 8'h00);
    #1;
    checks++;
    if (cpu_din_o !== 8'h01) begin errors++; $display("FAIL status_full got %h want 01", cpu_din_o); end
    cyc();
    idle();
    #1;
    checks++;
    if (cpu_din_o !== 8'h00) begin errors++; $display("FAIL bad_offset_read got %h want 00", cpu_din_o); end
  endtask

  task automatic test_full_pop_write();
    logic [7:0] exp_q [7];
    exp_q = '{8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h99};
    tx_ready_i = 1'b1;
    drive(32'h0003_0000, 1'b1, 8'hEE);
    #1;
    checks++;
    if (halt_req_o !== 2'b01) begin errors++; $display("FAIL collide_halt got %b want 01", halt_req_o); end
    cyc();
    tx_ready_i = 1'b0;
    idle();
    #1;
    checks++;
    if (halt_req_o !== 2'b00) begin errors++; $display("FAIL collide_halt_clear got %b want 00", halt_req_o); end
    drive(32'h0003_0004, 1'b0, 8'h00);
    cyc();
    idle();
    #1;
    checks++;
    if (cpu_din_o !== 8'h00) begin errors++; $display("FAIL collide_status got %h want 00", cpu_din_o); end
    tx_ready_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (tx_valid_o !== 1'b1 || tx_data_o !== exp_q[i]) begin
        errors++; $display("FAIL drain_%0d got %b/%h want 1/%h", i, tx_valid_o, tx_data_o, exp_q[i]);
      end
      cyc();
    end
    checks++;
    if (tx_valid_o !== 1'b0) begin errors++; $display("FAIL drain_empty got %b want 0", tx_valid_o); end
    tx_ready_i = 1'b0;
  endtask

  task automatic test_rx();
    ram_din_i = 8'hC3;
`ifdef IO_BRIDGE_RX_EN
    checks++;
    if (rx_ready_o !== 1'b1) begin errors++; $display("FAIL rx_ready got %b want 1", rx_ready_o); end
    rx_valid_i = 1'b1;
    rx_data_i  = 8'h5A;
    cyc();
    rx_valid_i = 1'b0;
    drive(32'h0003_0004, 1'b0, 8'h00);
    cyc();
    drive(32'h0003_0000, 1'b0, 8'h00);
    #1;
    checks++;
    if (cpu_din_o !== 8'h02) begin errors++; $display("FAIL rx_status got %h want 02", cpu_din_o); end
    cyc();
    drive(32'h0003_0000, 1'b0, 8'h00);
    #1;
    checks++;
    if (cpu_din_o !== 8'h5A) begin errors++; $display("FAIL rx_read got %h want 5a", cpu_din_o); end
    cyc();
    idle();
    #1;
    checks++;
    if (cpu_din_o !== 8'h00) begin errors++; $display("FAIL rx_empty_read got %h want 00", cpu_din_o); end
`else
    checks++;
    if (rx_ready_o !== 1'b0) begin errors++; $display("FAIL rx_ready got %b want 0", rx_ready_o); end
    rx_valid_i = 1'b1;
    rx_data_i  = 8'h5A;
    cyc();
    rx_valid_i = 1'b0;
    drive(32'h0003_0000, 1'b0, 8'h00);
    cyc();
    idle();
    #1;
    checks++;
    if (cpu_din_o !== 8'h00) begin errors++; $display("FAIL rx_off_read got %h want 00", cpu_din_o); end
`endif
  endtask

  task automatic test_reset_mid();
    tx_ready_i = 1'b0;
    drive(32'h0003_0000, 1'b1, 8'hAB);
    cyc();
    ram_din_i = 8'h5C;
    drive(32'h0003_0004, 1'b0, 8'h00);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    idle();
    #1;
    checks++;
    if (cpu_din_o !== 8'h5C || tx_valid_o !== 1'b0) begin
      errors++; $display("FAIL reset_mid got %h/%b want 5c/0", cpu_din_o, tx_valid_o);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_ram();
    test_tx_stream();
    test_tx_full();
    test_status();
    test_full_pop_write();
    test_rx();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
